// File: rtl/matvec_pkg.sv
// Shared types, sizes and the requantization arithmetic for the
// matrix-vector output stage.
package matvec_pkg;

  localparam int K       = 8;
  localparam int IN_W    = 28;
  localparam int OUT_W   = 14;
  localparam int SHIFT_W = 5;
  localparam int SATC_W  = 16;
  localparam int CNT_W   = $clog2(K);
  localparam int EXT_W   = IN_W + 1;

  typedef logic signed [IN_W-1:0]  y_t;
  typedef logic signed [OUT_W-1:0] x_t;
  typedef logic [SHIFT_W-1:0]      shamt_t;
  typedef logic signed [EXT_W-1:0] ext_t;

  // Result of one requantization: the clamped value and whether the clamp bit.
  typedef struct packed {
    x_t   data;
    logic sat;
  } rq_t;

  // One FIFO entry: requantized element plus end-of-vector tag.
  typedef struct packed {
    x_t   data;
    logic last;
  } entry_t;

  localparam ext_t SAT_MAX = ext_t'((1 << (OUT_W - 1)) - 1);
  localparam ext_t SAT_MIN = -ext_t'(1 << (OUT_W - 1));

  // Optional ReLU, round-half-up arithmetic right shift, then clamp to OUT_W.
  // The extra bit over IN_W keeps the rounding bias from overflowing.
  function automatic rq_t requant(input y_t y, input shamt_t s, input logic relu);
    ext_t r;
    ext_t q;
    ext_t bias;
    rq_t  res;
    r = (relu && (y < 0)) ? '0 : ext_t'(y);
    if (s == '0) begin
      q = r;
    end else begin
      bias = ext_t'(1) << (s - 1'b1);
      q    = (r + bias) >>> s;
    end
    if (q > SAT_MAX) begin
      res.data = x_t'(SAT_MAX);
      res.sat  = 1'b1;
    end else if (q < SAT_MIN) begin
      res.data = x_t'(SAT_MIN);
      res.sat  = 1'b1;
    end else begin
      res.data = x_t'(q);
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO of {data, last} with occupancy count.
// The caller never pushes when full; pops on an empty FIFO are ignored.
module fifo2
  import matvec_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  entry_t     i_din,
  input  logic       i_pop,
  output entry_t     o_dout,
  output logic       o_valid,
  output logic       o_full
);

  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);

  // Storage, pointers and count; head entry stays put until it is popped.
  // NOTE: storage is reset here only so the data output reads 0 during reset;
  // larger memories would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/matvec_out_requant.sv
// Output stage of the 8x8 matrix-vector unit: requantizes each 28-bit
// result to 14 bits, tags the last element of every vector, buffers two
// elements and counts saturation events.
module matvec_out_requant
  import matvec_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [SHIFT_W-1:0] shift,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [SATC_W-1:0] sat_count
);

  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;
  shamt_t            r_shift;
  logic              r_relu;
  logic [SATC_W-1:0] r_sat_count;

  logic   w_accept;
  logic   w_first;
  logic   w_full;
  logic   w_fifo_valid;
  shamt_t w_shift;
  logic   w_relu;
  rq_t    w_rq;
  entry_t w_din;
  entry_t w_dout;

  // Readiness depends only on FIFO occupancy, never on out_ready.
  assign in_ready = r_run && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_cnt == '0);

  // Element 0 uses the live config; the rest of the vector uses the latched copy.
  assign w_shift = w_first ? shift   : r_shift;
  assign w_relu  = w_first ? relu_en : r_relu;

  // Requantize and tag the incoming element.
  always_comb begin
    w_rq       = requant(y_t'(in_data), w_shift, w_relu);
    w_din.data = w_rq.data;
    w_din.last = (r_cnt == CNT_W'(K - 1));
  end

  fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_din   (w_din),
    .i_pop   (out_ready),
    .o_dout  (w_dout),
    .o_valid (w_fifo_valid),
    .o_full  (w_full)
  );

  assign out_valid = w_fifo_valid;
  assign out_data  = w_dout.data;
  assign out_last  = w_dout.last;
  assign sat_count = r_sat_count;

  // Hold off input acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  // Element position within the vector and per-vector config latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= (r_cnt == CNT_W'(K - 1)) ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_shift <= shift;
        r_relu  <= relu_en;
      end
    end
  end

  // Saturation event counter, sticks at its maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_count <= '0;
    end else if (w_accept && w_rq.sat && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

endmodule

// File: doc/matvec_out_requant.md
Name: matvec_out_requant

Overview:
Downstream stage of the 8x8 matrix-vector unit. Consumes the signed 28-bit y stream (K results per vector) over a valid/ready handshake. Applies optional ReLU, a round-half-up arithmetic right shift and saturation to 14 bits, so the results can be fed back as the next layer's 14-bit input vector. Tags the last element of each vector and counts saturation events.

Parameters:
K, 8, elements per output vector
IN_W, 28, input result width (signed)
OUT_W, 14, output data width (signed)
SHIFT_W, 5, width of the shift amount
SATC_W, 16, width of the saturation counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_data is valid
in_ready  out  1  stage can accept in_data
in_data  in  IN_W  signed y element from the matvec unit
shift  in  SHIFT_W  right-shift amount; latched at element 0 of each vector
relu_en  in  1  clamp negatives to 0; latched at element 0 of each vector
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts out_data
out_data  out  OUT_W  requantized signed element
out_last  out  1  out_data is element K-1 of its vector
sat_count  out  SATC_W  number of saturated elements since reset, sticks at max

Behaviour:
- Accept occurs on a rising edge with in_valid and in_ready both 1. Emit occurs on a rising edge with out_valid and out_ready both 1.
- Reset (reset_n=0, asynchronous): FIFO empty, element counter 0, sat_count 0, latched shift/relu 0. While reset_n=0: out_valid=0, out_last=0, out_data=0, in_ready=0. in_ready rises in the first cycle after reset_n deasserts.
- Reset mid-vector discards all buffered data. The next accepted element is element 0.
- Datapath is combinational from the accepted element into a 2-entry FIFO of {data, last}. Latency: an element accepted at edge n is presented with out_valid=1 after edge n, so it can be emitted at edge n+1.
- in_ready = (fifo_count < 2). It must not depend combinationally on out_ready. When full, in_ready=0 even if a pop happens in the same cycle.
- A simultaneous push and pop with count=1 leaves count=1. With out_ready held high, throughput is 1 element per cycle.
- The FIFO preserves order. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Element counter: 0..K-1, advances per accept, wraps from K-1 to 0. An entry is tagged last=1 when counter==K-1.
- shift and relu_en are captured on accept when counter==0. The element 0 computation itself uses the new values. Changes mid-vector are ignored until the next element 0.
- Arithmetic, using signed IN_W+1 bits:
  - r = (relu && x<0) ? 0 : x
  - s==0: q = r; otherwise q = (r + 2^(s-1)) >>> s (arithmetic shift)
  - Output is q clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8192, 8191].
- Saturation event: the clamp changed the value. sat_count increments by 1 per accepted saturating element and sticks at 2^SATC_W-1.

Decomposition:
- Package matvec_pkg:
  - constants K, IN_W, OUT_W
  - typedefs y_t (signed IN_W), x_t (signed OUT_W), shamt_t
  - function requant(y_t, shamt_t, relu) returning {x_t, sat_flag}
- Sub-module fifo2 (2-entry synchronous FIFO with count; async active-low reset) holds {x_t, last}.
- Top level holds the counter, the config latches, the requant function call and sat_count.

Test Plan:
1. shift=0, relu_en=0, in 100, out_ready=1 -> out_data=100 one cycle after accept; out_last=0.
2. shift=4: inputs 24, 23, -24, -25 -> 2, 1, -1, -2.
3. shift=0: inputs 10000, -10000, 8191 -> 8191, -8192, 8191; sat_count=2.
4. relu_en=1, shift=0: 8 inputs -5000, 7, ... -> first output 0; out_last=1 only on the 8th output.
5. out_ready=0, in_valid=1 continuously -> exactly 2 accepts, then in_ready=0. After out_ready=1, outputs drain in order and in_ready returns the next cycle.
6. shift changed 0->4 at element 3 -> elements 3..7 unshifted, next vector shifted. reset_n pulsed low after element 5 -> out_valid=0 immediately; the next accepted input is element 0 (out_last on its 8th output).
